// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp_pkg
// Brief    : Shared types and helpers for the FP normalize/round datapath.
// Revision : 1.0 - initial release
// ============================================================================
package fp_pkg;

    typedef struct packed {
        logic ovf;
        logic unf;
        logic inx;
        logic zero;
    } fp_flags_t;

    // Bit positions of the low end of a normalized significand
    localparam int c_S_IDX   = 0;
    localparam int c_R_IDX   = 1;
    localparam int c_G_IDX   = 2;
    localparam int c_LSB_IDX = 3;

    function automatic int exp_max(input int ew);
        return (1 << ew) - 1;
    endfunction

    function automatic int exp_bias(input int ew);
        return (1 << (ew - 1)) - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_normalize_round_if.sv
`default_nettype none
// ============================================================================
// Module   : fp_normalize_round_if
// Brief    : Valid/ready input and result buses of the normalize/round stage.
// Revision : 1.0 - initial release
// ============================================================================
interface fp_normalize_round_if #(
    parameter int EXP_WIDTH  = 8,
    parameter int MANT_WIDTH = 23
);
    localparam int SIG_WIDTH = MANT_WIDTH + 5;

    logic                              in_valid;
    logic                              in_ready;
    logic                              in_sign;
    logic signed [EXP_WIDTH+1:0]       in_exp;
    logic        [SIG_WIDTH-1:0]       in_sig;
    logic                              out_valid;
    logic                              out_ready;
    logic        [EXP_WIDTH+MANT_WIDTH:0] out_result;
    logic        [3:0]                 out_flags;

    modport master (
        output in_valid, in_sign, in_exp, in_sig, out_ready,
        input  in_ready, out_valid, out_result, out_flags
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_sig, out_ready,
        output in_ready, out_valid, out_result, out_flags
    );
endinterface
`default_nettype wire

// File: rtl/fp_normalize_round_lod.sv
`default_nettype none
// ============================================================================
// Module   : leading_one_detector
// Brief    : Position of the most significant set bit, plus a non-zero flag.
// Revision : 1.0 - initial release
// ============================================================================
module leading_one_detector #(
    parameter int WIDTH = 28
) (
    input  wire  [WIDTH-1:0]         i_vec,
    output logic [$clog2(WIDTH)-1:0] o_pos,
    output logic                     has_leading_one
);
    localparam int POS_W = $clog2(WIDTH);

    always_comb begin
        o_pos           = '0;
        has_leading_one = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i_vec[i]) begin
                o_pos           = POS_W'(i);
                has_leading_one = 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/fp_normalize_round.sv
`default_nettype none
// ============================================================================
// Module   : fp_normalize_round
// Brief    : 2-stage normalize + round-to-nearest-even + pack, with flags.
//            FP_NORMALIZE_SUBNORMAL_EN: gradual underflow; otherwise flush to zero.
// Revision : 1.0 - initial release
// ============================================================================
module fp_normalize_round
    import fp_pkg::*;
#(
    parameter int EXP_WIDTH  = 8,
    parameter int MANT_WIDTH = 23,
    parameter int SIG_WIDTH  = MANT_WIDTH + 5
) (
    input wire clk,
    input wire rst,
    fp_normalize_round_if.slave bus
);
    localparam int NORM_W = SIG_WIDTH - 1;     // hidden .. sticky
    localparam int XW     = EXP_WIDTH + 3;     // extra headroom so exponent math never wraps
    localparam int POS_W  = $clog2(SIG_WIDTH);
    localparam int SUM_W  = MANT_WIDTH + 2;

    logic                    r_s1_valid;
    logic                    r_s1_sign;
    logic                    r_s1_zero;
    logic                    r_s1_flush;
    logic                    r_s1_tiny;
    logic [NORM_W-1:0]       r_s1_sig;
    logic signed [XW-1:0]    r_s1_exp;
    logic                    r_s2_valid;
    logic [EXP_WIDTH+MANT_WIDTH:0] r_result;
    fp_flags_t               r_flags;

    logic w_s1_ready, w_s2_ready;
    assign w_s2_ready   = !r_s2_valid || bus.out_ready;
    assign w_s1_ready   = !r_s1_valid || w_s2_ready;
    assign bus.in_ready = w_s1_ready;

    // ---------------- Stage 1: normalize ----------------
    logic [POS_W-1:0]     w_pos, w_lz;
    logic                 w_nonzero, w_tiny;
    logic signed [XW-1:0] w_exp_in, w_norm_exp, w_s1_exp;
    logic [NORM_W-1:0]    w_norm_l, w_norm_sig, w_s1_sig;
    logic                 w_s1_flush;

    leading_one_detector #(.WIDTH(SIG_WIDTH)) u_lod (
        .i_vec           (bus.in_sig),
        .o_pos           (w_pos),
        .has_leading_one (w_nonzero)
    );

    assign w_exp_in = {bus.in_exp[EXP_WIDTH+1], bus.in_exp};
    assign w_lz     = POS_W'(SIG_WIDTH - 2) - w_pos;
    assign w_norm_l = NORM_W'(bus.in_sig << w_lz);

    always_comb begin
        if (w_pos == POS_W'(SIG_WIDTH - 1)) begin
            w_norm_sig = {bus.in_sig[SIG_WIDTH-1:2], |bus.in_sig[1:0]};
            w_norm_exp = w_exp_in + XW'(1);
        end else begin
            w_norm_sig = w_norm_l;
            w_norm_exp = w_exp_in - XW'(w_lz);
        end
    end

    assign w_tiny = w_norm_exp[XW-1] || (w_norm_exp == '0);

`ifdef FP_NORMALIZE_SUBNORMAL_EN
    logic [XW-1:0]       w_rsh;
    logic [2*NORM_W-1:0] w_den;

    always_comb begin
        w_rsh = XW'(1) - w_norm_exp;
        if (w_rsh > XW'(MANT_WIDTH + 3)) begin
            w_rsh = XW'(MANT_WIDTH + 3);
        end
        w_den      = {w_norm_sig, {NORM_W{1'b0}}} >> w_rsh;
        w_s1_flush = 1'b0;
        if (w_tiny) begin
            w_s1_sig = {w_den[2*NORM_W-1:NORM_W+1], w_den[NORM_W] | (|w_den[NORM_W-1:0])};
            w_s1_exp = '0;
        end else begin
            w_s1_sig = w_norm_sig;
            w_s1_exp = w_norm_exp;
        end
    end
`else
    always_comb begin
        w_s1_sig   = w_norm_sig;
        w_s1_exp   = w_norm_exp;
        w_s1_flush = w_tiny;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
        end else if (w_s1_ready) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_sign  <= bus.in_sign;
                r_s1_zero  <= !w_nonzero;
                r_s1_flush <= w_s1_flush;
                r_s1_tiny  <= w_tiny;
                r_s1_sig   <= w_s1_sig;
                r_s1_exp   <= w_s1_exp;
            end
        end
    end

    // ---------------- Stage 2: round and pack ----------------
    logic                          w_inc, w_inx;
    logic [SUM_W-1:0]              w_sum;
    logic signed [XW-1:0]          w_exp_r;
    logic [EXP_WIDTH+MANT_WIDTH:0] w_result;
    fp_flags_t                     w_flags;

    assign w_inc = r_s1_sig[c_G_IDX] & (r_s1_sig[c_R_IDX] | r_s1_sig[c_S_IDX] | r_s1_sig[c_LSB_IDX]);
    assign w_inx = r_s1_sig[c_G_IDX] | r_s1_sig[c_R_IDX] | r_s1_sig[c_S_IDX];
    assign w_sum = {1'b0, r_s1_sig[NORM_W-1:c_LSB_IDX]} + SUM_W'(w_inc);
    // Integer part of the rounded significand replaces the hidden bit: covers
    // fraction wrap (exp+1) and subnormal promotion (exp 0 -> 1) alike.
    assign w_exp_r = r_s1_exp - XW'(r_s1_sig[NORM_W-1]) + XW'(w_sum[SUM_W-1:MANT_WIDTH]);

    always_comb begin
        w_flags  = '0;
        w_result = {r_s1_sign, {(EXP_WIDTH + MANT_WIDTH){1'b0}}};
        if (r_s1_zero) begin
            w_flags.zero = 1'b1;
        end else if (r_s1_flush) begin
            w_flags.unf  = 1'b1;
            w_flags.inx  = 1'b1;
            w_flags.zero = 1'b1;
        end else if (!w_exp_r[XW-1] && (w_exp_r >= XW'(exp_max(EXP_WIDTH)))) begin
            w_result    = {r_s1_sign, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
            w_flags.ovf = 1'b1;
            w_flags.inx = 1'b1;
        end else begin
            w_result     = {r_s1_sign, w_exp_r[EXP_WIDTH-1:0], w_sum[MANT_WIDTH-1:0]};
            w_flags.inx  = w_inx;
            w_flags.unf  = r_s1_tiny & w_inx;
            w_flags.zero = (w_exp_r == '0) && (w_sum[MANT_WIDTH-1:0] == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_result   <= '0;
            r_flags    <= '0;
        end else if (w_s2_ready) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_result <= w_result;
                r_flags  <= w_flags;
            end
        end
    end

    assign bus.out_valid  = r_s2_valid;
    assign bus.out_result = r_result;
    assign bus.out_flags  = r_flags;
endmodule
`default_nettype wire

// File: tb/tb_fp_normalize_round.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_normalize_round
// Brief    : Directed table, random model-checked stream, back-pressure and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_normalize_round;
    localparam int EW = 8;
    localparam int MW = 23;
    localparam int SW = MW + 5;
    localparam int NV = 12;
    localparam logic [SW-1:0] HID = 28'h4000000;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  fl;
    } exp_t;

    typedef struct {
        string                 name;
        logic                  sign;
        logic signed [EW+1:0]  exp;
        logic [SW-1:0]         sig;
        logic [31:0]           res;
        logic [3:0]            fl;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp_normalize_round_if #(.EXP_WIDTH(EW), .MANT_WIDTH(MW)) bus ();

    fp_normalize_round #(.EXP_WIDTH(EW), .MANT_WIDTH(MW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_out   = 0;
    bit   use_sb  = 0;
    bit   rand_mode = 0;
    exp_t exp_q[$];
    vec_t vecs[NV];

    // Reference: exact value M * 2^(e - (SW-2)), rounded RNE at the format's quantum.
    function automatic exp_t model(input logic s, input logic signed [EW+1:0] e, input logic [SW-1:0] m);
        exp_t   r;
        int     p, eu, k, ef;
        longint q, rem, half;
        logic   inx;
        r.res = '0;
        r.fl  = '0;
        if (m == '0) begin
            r.res = {s, 31'b0};
            r.fl  = 4'b0001;
            return r;
        end
        p = 0;
        for (int i = 0; i < SW; i++) if (m[i]) p = i;
        eu = int'(e) + p - (SW - 2);
`ifndef FP_NORMALIZE_SUBNORMAL_EN
        if (eu < 1) begin
            r.res = {s, 31'b0};
            r.fl  = 4'b0111;
            return r;
        end
`endif
        k = p - MW + ((eu < 1) ? (1 - eu) : 0);
        if (k <= 0) begin
            q = longint'(m) << (-k); rem = 0; half = 0;
        end else if (k > 60) begin
            q = 0; rem = 1; half = 64'sh4000_0000_0000_0000;
        end else begin
            q    = longint'(m) >> k;
            rem  = longint'(m) & ((64'sd1 << k) - 1);
            half = 64'sd1 << (k - 1);
        end
        inx = (rem != 0);
        if (rem > half || (rem == half && rem != 0 && q[0])) q++;
        if (eu < 1) begin
            ef = int'(q >> MW);
        end else begin
            ef = eu;
            if ((q >> (MW + 1)) != 0) begin
                ef++;
                q = q >> 1;
            end
        end
        if (ef >= (1 << EW) - 1) begin
            r.res = {s, 8'hFF, 23'b0};
            r.fl  = 4'b1010;
            return r;
        end
        r.res = {s, ef[EW-1:0], q[MW-1:0]};
        r.fl  = {1'b0, (eu < 1) && inx, inx, (ef == 0) && (q[MW-1:0] == 0)};
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_mode) bus.out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input logic s, input logic signed [EW+1:0] e, input logic [SW-1:0] m,
                        input exp_t ev, input bit push);
        int  guard;
        bit  ok;
        guard = 0;
        ok    = 1;
        bus.in_valid = 1'b1;
        bus.in_sign  = s;
        bus.in_exp   = e;
        bus.in_sig   = m;
        while (1) begin
            @(negedge clk);
            if (bus.in_ready) break;
            guard++;
            if (guard > 100) begin
                n_tests++;
                n_fail++;
                $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", guard);
                ok = 0;
                break;
            end
            step();
        end
        if (ok && push) exp_q.push_back(ev);
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 300) begin
            step();
            guard++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else if (use_sb && bus.out_valid && bus.out_ready) begin
            exp_t ev;
            n_out++;
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output: got res=%h flags=%b, expected no output",
                         bus.out_result, bus.out_flags);
            end else begin
                ev = exp_q.pop_front();
                if (bus.out_result !== ev.res || bus.out_flags !== ev.fl) begin
                    n_fail++;
                    $display("FAIL stream_result: got res=%h flags=%b, expected res=%h flags=%b",
                             bus.out_result, bus.out_flags, ev.res, ev.fl);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        int   snap;
        exp_t ev;

        vecs[0]  = '{"normal",      1'b0, 10'sd127, HID,                       32'h3F80_0000, 4'b0000};
        vecs[1]  = '{"carry",       1'b0, 10'sd127, 28'h8000000,               32'h4000_0000, 4'b0000};
        vecs[2]  = '{"left_shift",  1'b0, 10'sd130, 28'h0200000,               32'h3E80_0000, 4'b0000};
        vecs[3]  = '{"rne_wrap",    1'b0, 10'sd127, 28'h7FFFFFC,               32'h4000_0000, 4'b0010};
        vecs[4]  = '{"tie_even",    1'b0, 10'sd127, 28'h4000014,               32'h3F80_0002, 4'b0010};
        vecs[5]  = '{"tie_odd",     1'b0, 10'sd127, 28'h400001C,               32'h3F80_0004, 4'b0010};
        vecs[6]  = '{"round_gs",    1'b0, 10'sd127, 28'h4000005,               32'h3F80_0001, 4'b0010};
        vecs[7]  = '{"overflow",    1'b0, 10'sd254, 28'h7FFFFFC,               32'h7F80_0000, 4'b1010};
        vecs[8]  = '{"zero",        1'b1, 10'sd5,   28'h0000000,               32'h8000_0000, 4'b0001};
`ifdef FP_NORMALIZE_SUBNORMAL_EN
        vecs[9]  = '{"under_exact", 1'b0, -10'sd3,  HID,                       32'h0008_0000, 4'b0000};
        vecs[10] = '{"under_neg_s", 1'b1, -10'sd3,  28'h4000001,               32'h8008_0000, 4'b0110};
        vecs[11] = '{"sub_to_norm", 1'b0, 10'sd0,   28'h7FFFFFC,               32'h0080_0000, 4'b0110};
`else
        vecs[9]  = '{"under_exact", 1'b0, -10'sd3,  HID,                       32'h0000_0000, 4'b0111};
        vecs[10] = '{"under_neg_s", 1'b1, -10'sd3,  28'h4000001,               32'h8000_0000, 4'b0111};
        vecs[11] = '{"sub_to_norm", 1'b0, 10'sd0,   28'h7FFFFFC,               32'h0000_0000, 4'b0111};
`endif

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_sign   = 1'b0;
        bus.in_exp    = '0;
        bus.in_sig    = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid",  64'(bus.out_valid),  64'd0);
        check("reset_in_ready",   64'(bus.in_ready),   64'd1);
        check("reset_out_result", 64'(bus.out_result), 64'd0);
        check("reset_out_flags",  64'(bus.out_flags),  64'd0);
        rst = 1'b0;
        step();

        // Directed table: one beat at a time, latency counted in cycles from accept
        for (int i = 0; i < NV; i++) begin
            ev.res = vecs[i].res;
            ev.fl  = vecs[i].fl;
            send(vecs[i].sign, vecs[i].exp, vecs[i].sig, ev, 1'b0);
            lat = 1;
            while (!bus.out_valid && lat < 10) begin
                step();
                lat++;
            end
            check({vecs[i].name, "_latency"}, 64'(lat), 64'd2);
            check({vecs[i].name, "_result"},  64'(bus.out_result), 64'(vecs[i].res));
            check({vecs[i].name, "_flags"},   64'(bus.out_flags),  64'(vecs[i].fl));
        end
        step();

        // Random stream against the reference model with random back-pressure
        use_sb    = 1;
        rand_mode = 1;
        for (int n = 0; n < 300; n++) begin
            logic                 s;
            logic signed [EW+1:0] e;
            logic [SW-1:0]        m;
            int                   ei;
            int                   mode;
            mode = int'($urandom_range(0, 3));
            s    = 1'($urandom_range(0, 1));
            ei   = int'($urandom_range(0, 300)) - 20;
            case (mode)
                0: m = SW'($urandom());
                1: m = SW'($urandom() >> $urandom_range(4, 31));
                2: m = HID | (SW'($urandom()) & 28'h3FFFFF8) | 28'h0000004;
                default: begin
                    m  = SW'($urandom());
                    ei = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 30)) - 28
                                                     : int'($urandom_range(248, 258));
                end
            endcase
            e = ei[EW+1:0];
            send(s, e, m, model(s, e, m), 1'b1);
            if ($urandom_range(0, 3) == 0) step();
        end
        rand_mode     = 0;
        bus.out_ready = 1'b1;
        wait_drain("random_drain");

        // Back-pressure: 4 beats while the consumer stalls for 5 cycles
        snap          = n_out;
        bus.out_ready = 1'b0;
        send(1'b0, 10'sd127, 28'h4000008, model(1'b0, 10'sd127, 28'h4000008), 1'b1);
        send(1'b1, 10'sd128, 28'h4000010, model(1'b1, 10'sd128, 28'h4000010), 1'b1);
        check("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
        bus.in_valid = 1'b1;
        bus.in_sign  = 1'b0;
        bus.in_exp   = 10'sd129;
        bus.in_sig   = 28'h4000018;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_hold_in_ready",  64'(bus.in_ready),  64'd0);
            check("bp_hold_out_valid", 64'(bus.out_valid), 64'd1);
            step();
        end
        bus.out_ready = 1'b1;
        send(1'b0, 10'sd129, 28'h4000018, model(1'b0, 10'sd129, 28'h4000018), 1'b1);
        send(1'b1, 10'sd126, 28'h0800000, model(1'b1, 10'sd126, 28'h0800000), 1'b1);
        wait_drain("bp_drain");
        repeat (2) step();
        check("bp_beat_count", 64'(n_out - snap), 64'd4);

        // Reset with two beats in flight: they must never emerge
        bus.out_ready = 1'b0;
        send(1'b0, 10'sd127, HID, model(1'b0, 10'sd127, HID), 1'b1);
        send(1'b0, 10'sd100, HID, model(1'b0, 10'sd100, HID), 1'b1);
        rst = 1'b1;
        step();
        check("rst_out_valid",  64'(bus.out_valid),  64'd0);
        check("rst_out_result", 64'(bus.out_result), 64'd0);
        check("rst_out_flags",  64'(bus.out_flags),  64'd0);
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        snap          = n_out;
        repeat (8) step();
        check("rst_no_ghost_beats", 64'(n_out - snap), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
